imm_gen_stage: RTL and testbench

Registered immediate-generation stage between decode and execute. Extracts the immediate bit-fields directly from the raw 32-bit instruction word according to instr_type_t, then sign- or zero-extends the result to wd_regs_p bits. It carries the result plus a sideband tag through a 2-entry skid buffer with valid/ready handshakes on both sides. It also supports flush and flags out-of-range shift amounts.

---
 rtl/arriskv_pkg.sv | 19 +
 rtl/imm_gen_stage_imm_extract.sv | 44 ++++
 rtl/imm_gen_stage.sv | 114 +++++++++++
 tb/tb_imm_gen_stage.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/arriskv_pkg.sv
// Shared decode-side types for the arriskv pipeline: instruction formats and
// the raw instruction width.
package arriskv_pkg;

  localparam int unsigned INSTR_W = 32;

  typedef enum logic [3:0] {
    TypeR  = 4'd0,
    TypeI  = 4'd1,
    TypeIJ = 4'd2,
    TypeIL = 4'd3,
    TypeIS = 4'd4,
    TypeS  = 4'd5,
    TypeB  = 4'd6,
    TypeU  = 4'd7,
    TypeJ  = 4'd8
  } instr_type_t;

endpackage

// File: rtl/imm_gen_stage_imm_extract.sv
// Combinational immediate extraction from a raw instruction word, extended to
// the datapath width, with a flag for shift amounts that do not fit.
module imm_extract
  import arriskv_pkg::*;
#(
  parameter int unsigned wd_regs_p = 32
) (
  input  logic [INSTR_W-1:0]   instr,
  input  instr_type_t          instr_type,
  output logic [wd_regs_p-1:0] imm,
  output logic                 illegal
);

  // 32-bit signed form of the immediate; widened by sign extension below.
  logic [31:0] raw;
  logic        unused_opcode;

  assign unused_opcode = ^instr[6:0];

  always_comb begin
    raw     = '0;
    illegal = 1'b0;
    case (instr_type)
      TypeI, TypeIJ, TypeIL: raw = {{20{instr[31]}}, instr[31:20]};
      TypeIS: begin
        if (wd_regs_p == 32) begin
          raw     = {27'b0, instr[24:20]};
          illegal = instr[25];
        end else begin
          raw = {26'b0, instr[25:20]};
        end
      end
      TypeS:   raw = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      TypeB:   raw = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
      TypeU:   raw = {instr[31:12], 12'h000};
      TypeJ:   raw = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
      default: raw = '0;
    endcase
  end

  // Zero-extended formats keep bit 31 clear, so a signed widen is safe for all.
  assign imm = wd_regs_p'($signed(raw));

endmodule

// File: rtl/imm_gen_stage.sv
// Registered immediate-generation stage: extracts the immediate, then carries
// it with a sideband tag through a 2-entry skid buffer.
module imm_gen_stage
  import arriskv_pkg::*;
#(
  parameter int unsigned wd_regs_p = 32,
  parameter int unsigned wd_tag_p  = 32
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_flush,
  input  logic                 i_valid,
  output logic                 o_ready,
  input  logic [INSTR_W-1:0]   i_instr,
  input  instr_type_t          i_instr_type,
  input  logic [wd_tag_p-1:0]  i_tag,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic [wd_regs_p-1:0] o_imm,
  output instr_type_t          o_instr_type,
  output logic [wd_tag_p-1:0]  o_tag,
  output logic                 o_illegal
);

  if (wd_regs_p != 32 && wd_regs_p != 64) begin : g_bad_width
    $error("imm_gen_stage: wd_regs_p must be 32 or 64");
  end

  typedef struct packed {
    logic [wd_regs_p-1:0] imm;
    instr_type_t          instr_type;
    logic                 illegal;
  } imm_entry_t;

  imm_entry_t          new_entry;
  imm_entry_t          main_q, skid_q;
  logic [wd_tag_p-1:0] main_tag_q, skid_tag_q;
  logic                main_valid_q, main_valid_d;
  logic                skid_valid_q, skid_valid_d;
  logic                accept, retire, main_free;
  logic                load_main, main_from_skid, load_skid;

  imm_extract #(
    .wd_regs_p (wd_regs_p)
  ) u_imm_extract (
    .instr      (i_instr),
    .instr_type (i_instr_type),
    .imm        (new_entry.imm),
    .illegal    (new_entry.illegal)
  );

  assign new_entry.instr_type = i_instr_type;

  assign o_ready   = ~skid_valid_q;
  assign accept    = i_valid & o_ready;
  assign retire    = main_valid_q & i_ready;
  assign main_free = ~main_valid_q | retire;

  always_comb begin
    main_valid_d   = main_valid_q;
    skid_valid_d   = skid_valid_q;
    load_main      = 1'b0;
    main_from_skid = 1'b0;
    load_skid      = 1'b0;
    if (i_flush) begin
      // A retiring entry still leaves this cycle; anything accepted is dropped.
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (main_free) begin
      if (skid_valid_q) begin
        load_main      = 1'b1;
        main_from_skid = 1'b1;
        main_valid_d   = 1'b1;
        skid_valid_d   = accept;
        load_skid      = accept;
      end else begin
        main_valid_d = accept;
        load_main    = accept;
      end
    end else if (accept) begin
      skid_valid_d = 1'b1;
      load_skid    = 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      main_q       <= '0;
      skid_q       <= '0;
      main_tag_q   <= '0;
      skid_tag_q   <= '0;
    end else begin
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
      if (load_main) begin
        main_q     <= main_from_skid ? skid_q : new_entry;
        main_tag_q <= main_from_skid ? skid_tag_q : i_tag;
      end
      if (load_skid) begin
        skid_q     <= new_entry;
        skid_tag_q <= i_tag;
      end
    end
  end

  assign o_valid      = main_valid_q;
  assign o_imm        = main_q.imm;
  assign o_instr_type = main_q.instr_type;
  assign o_illegal    = main_q.illegal;
  assign o_tag        = main_tag_q;

endmodule

// File: tb/tb_imm_gen_stage.sv
// Bench for imm_gen_stage: 32- and 64-bit instances share stimulus and are
// compared against a 2-deep FIFO model with arithmetic immediate decoding.
module tb_imm_gen_stage;
  import arriskv_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        flush = 1'b0;
  logic        valid = 1'b0;
  logic        ready = 1'b0;
  logic [31:0] instr = '0;
  instr_type_t itype = TypeR;
  logic [31:0] tag = '0;

  logic        o_ready32, o_valid32, o_ill32;
  logic [31:0] o_imm32, o_tag32;
  instr_type_t o_type32;
  logic        o_ready64, o_valid64, o_ill64;
  logic [63:0] o_imm64;
  logic [31:0] o_tag64;
  instr_type_t o_type64;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [63:0] imm32;
    logic [63:0] imm64;
    logic        ill32;
    logic        ill64;
    instr_type_t ty;
    logic [31:0] tg;
  } exp_t;

  exp_t model_q[$];

  always #5 clk = ~clk;

  imm_gen_stage #(.wd_regs_p(32), .wd_tag_p(32)) dut32 (
    .i_clk(clk), .i_rst(rst), .i_flush(flush), .i_valid(valid), .o_ready(o_ready32),
    .i_instr(instr), .i_instr_type(itype), .i_tag(tag), .o_valid(o_valid32),
    .i_ready(ready), .o_imm(o_imm32), .o_instr_type(o_type32), .o_tag(o_tag32),
    .o_illegal(o_ill32)
  );

  imm_gen_stage #(.wd_regs_p(64), .wd_tag_p(32)) dut64 (
    .i_clk(clk), .i_rst(rst), .i_flush(flush), .i_valid(valid), .o_ready(o_ready64),
    .i_instr(instr), .i_instr_type(itype), .i_tag(tag), .o_valid(o_valid64),
    .i_ready(ready), .o_imm(o_imm64), .o_instr_type(o_type64), .o_tag(o_tag64),
    .o_illegal(o_ill64)
  );

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Immediate value as the signed offset the format encodes.
  function automatic logic [63:0] ref_imm(input logic [31:0] ins, input instr_type_t ty,
                                          input int w);
    longint v;
    v = 0;
    case (ty)
      TypeI, TypeIJ, TypeIL: v = (ins[31] ? -2048 : 0) + longint'(ins[30:20]);
      TypeIS: v = (w == 32) ? longint'(ins[24:20]) : longint'(ins[25:20]);
      TypeS: v = (ins[31] ? -2048 : 0) + longint'(ins[30:25]) * 32 + longint'(ins[11:7]);
      TypeB: v = (ins[31] ? -4096 : 0) + longint'(ins[7]) * 2048 + longint'(ins[30:25]) * 32
                 + longint'(ins[11:8]) * 2;
      TypeU: begin
        v = longint'(ins[31:12]) * 4096;
        if (ins[31]) v = v - 64'sh1_0000_0000;
      end
      TypeJ: v = (ins[31] ? -1048576 : 0) + longint'(ins[19:12]) * 4096
                 + longint'(ins[20]) * 2048 + longint'(ins[30:21]) * 2;
      default: v = 0;
    endcase
    return (w == 32) ? {32'b0, v[31:0]} : v;
  endfunction

  task automatic check_outputs();
    logic ev;
    ev = (model_q.size() > 0);
    check("o_valid32", {63'b0, o_valid32}, {63'b0, ev});
    check("o_valid64", {63'b0, o_valid64}, {63'b0, ev});
    check("o_ready32", {63'b0, o_ready32}, {63'b0, model_q.size() < 2});
    check("o_ready64", {63'b0, o_ready64}, {63'b0, model_q.size() < 2});
    if (ev) begin
      check("o_imm32", {32'b0, o_imm32}, model_q[0].imm32);
      check("o_imm64", o_imm64, model_q[0].imm64);
      check("o_illegal32", {63'b0, o_ill32}, {63'b0, model_q[0].ill32});
      check("o_illegal64", {63'b0, o_ill64}, {63'b0, model_q[0].ill64});
      check("o_type32", {60'b0, o_type32}, {60'b0, model_q[0].ty});
      check("o_type64", {60'b0, o_type64}, {60'b0, model_q[0].ty});
      check("o_tag32", {32'b0, o_tag32}, {32'b0, model_q[0].tg});
      check("o_tag64", {32'b0, o_tag64}, {32'b0, model_q[0].tg});
    end
  endtask

  task automatic check_reset();
    check("rst_valid", {62'b0, o_valid32, o_valid64}, 64'd0);
    check("rst_ready", {62'b0, o_ready32, o_ready64}, 64'd3);
    check("rst_imm32", {32'b0, o_imm32}, 64'd0);
    check("rst_imm64", o_imm64, 64'd0);
    check("rst_tag", {o_tag32, o_tag64}, 64'd0);
    check("rst_ill", {62'b0, o_ill32, o_ill64}, 64'd0);
    check("rst_type", {56'b0, o_type32, o_type64}, {56'b0, TypeR, TypeR});
  endtask

  // Drive one cycle from a negedge, advance the model at the posedge, check at next negedge.
  task automatic cycle(input logic v, input logic [31:0] ins, input instr_type_t ty,
                       input logic [31:0] tg, input logic rdy, input logic fl, input logic rs);
    exp_t e;
    logic acc, ret;
    valid = v; instr = ins; itype = ty; tag = tg; ready = rdy; flush = fl; rst = rs;
    acc = v && (model_q.size() < 2);
    ret = (model_q.size() > 0) && rdy;
    @(posedge clk);
    if (rs || fl) begin
      model_q.delete();
    end else begin
      if (ret) void'(model_q.pop_front());
      if (acc) begin
        e.imm32 = ref_imm(ins, ty, 32);
        e.imm64 = ref_imm(ins, ty, 64);
        e.ill32 = (ty == TypeIS) && ins[25];
        e.ill64 = 1'b0;
        e.ty    = ty;
        e.tg    = tg;
        model_q.push_back(e);
      end
    end
    @(negedge clk);
    check_outputs();
  endtask

  initial begin
    @(negedge clk);
    cycle(1'b0, '0, TypeR, '0, 1'b1, 1'b0, 1'b1);
    check_reset();

    // Back-to-back I, B, J, then U and IS formats at both widths.
    cycle(1'b1, 32'hFFF00093, TypeI, 32'h10, 1'b1, 1'b0, 1'b0);
    check("dir_i", {32'b0, o_imm32}, 64'hFFFF_FFFF);
    cycle(1'b1, 32'hFE000EE3, TypeB, 32'h11, 1'b1, 1'b0, 1'b0);
    check("dir_b", {32'b0, o_imm32}, 64'hFFFF_FFFC);
    cycle(1'b1, 32'h001000EF, TypeJ, 32'h12, 1'b1, 1'b0, 1'b0);
    check("dir_j", {32'b0, o_imm32}, 64'h0000_0800);
    cycle(1'b1, 32'h800000B7, TypeU, 32'h13, 1'b1, 1'b0, 1'b0);
    check("dir_u32", {32'b0, o_imm32}, 64'h8000_0000);
    check("dir_u64", o_imm64, 64'hFFFF_FFFF_8000_0000);
    cycle(1'b1, 32'h123450B7, TypeU, 32'h14, 1'b1, 1'b0, 1'b0);
    check("dir_u64b", o_imm64, 64'h0000_0000_1234_5000);
    cycle(1'b1, 32'h02009093, TypeIS, 32'h15, 1'b1, 1'b0, 1'b0);
    check("dir_is32_ill", {63'b0, o_ill32}, 64'd1);
    check("dir_is32_imm", {32'b0, o_imm32}, 64'd0);
    check("dir_is64_ill", {63'b0, o_ill64}, 64'd0);
    check("dir_is64_imm", o_imm64, 64'h20);
    cycle(1'b0, '0, TypeR, '0, 1'b1, 1'b0, 1'b0);

    // Backpressure: tags 1,2 buffered, 3 held off, then released in order.
    cycle(1'b1, $urandom, TypeI, 32'd1, 1'b0, 1'b0, 1'b0);
    check("bp_ready1", {63'b0, o_ready32}, 64'd1);
    cycle(1'b1, $urandom, TypeS, 32'd2, 1'b0, 1'b0, 1'b0);
    check("bp_ready2", {63'b0, o_ready32}, 64'd0);
    cycle(1'b1, $urandom, TypeB, 32'd3, 1'b0, 1'b0, 1'b0);
    check("bp_hold_tag", {32'b0, o_tag32}, 64'd1);
    cycle(1'b1, $urandom, TypeB, 32'd3, 1'b1, 1'b0, 1'b0);
    check("bp_tag2", {32'b0, o_tag32}, 64'd2);
    cycle(1'b1, $urandom, TypeB, 32'd3, 1'b1, 1'b0, 1'b0);
    check("bp_tag3", {32'b0, o_tag32}, 64'd3);
    cycle(1'b0, '0, TypeR, '0, 1'b1, 1'b0, 1'b0);
    check("bp_drained", {63'b0, o_valid32}, 64'd0);

    // Flush with a full buffer and a simultaneous new entry.
    cycle(1'b1, $urandom, TypeU, 32'd5, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, $urandom, TypeJ, 32'd6, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, $urandom, TypeI, 32'd7, 1'b0, 1'b1, 1'b0);
    check("fl_valid", {63'b0, o_valid32}, 64'd0);
    check("fl_ready", {63'b0, o_ready32}, 64'd1);
    cycle(1'b0, '0, TypeR, '0, 1'b1, 1'b0, 1'b0);
    check("fl_no_deliver", {63'b0, o_valid64}, 64'd0);

    // Reset while full, then a fresh accept.
    cycle(1'b1, $urandom, TypeU, 32'd8, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, $urandom, TypeS, 32'd9, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, $urandom, TypeB, 32'd10, 1'b0, 1'b0, 1'b1);
    check_reset();
    cycle(1'b1, 32'hFFF00093, TypeI, 32'd11, 1'b1, 1'b0, 1'b0);
    check("post_rst_imm", {32'b0, o_imm32}, 64'hFFFF_FFFF);
    check("post_rst_tag", {32'b0, o_tag32}, 64'd11);

    for (int i = 0; i < 3000; i++) begin
      cycle(($urandom_range(0, 3) != 0), $urandom, instr_type_t'(4'($urandom_range(0, 11))),
            $urandom, ($urandom_range(0, 2) != 0), ($urandom_range(0, 39) == 0),
            ($urandom_range(0, 199) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
